// File: rtl/aes_out_serializer.sv
// aes_out_serializer
//   Buffers 128-bit ciphertext blocks from the AES core in a 2-entry FIFO.
//   Each block is sent downstream as four 32-bit words with a valid/ready
//   handshake.
//
//   Parameter
//     MSW_FIRST          1: word 0 = bits [127:96]; 0: word 0 = bits [31:0]
//   Ports
//     AES_clk            clock, rising edge
//     AES_rst_n          asynchronous active-low reset
//     AES_data_out       128-bit block from the AES core
//     AES_data_out_valid core output valid (pulse or level)
//     ser_ready          downstream accepts ser_data this cycle
//     ser_ovf_clr        synchronous clear of ser_overflow
//     ser_data           current output word (0 when nothing is buffered)
//     ser_valid          ser_data is valid
//     ser_last           current word is word 3 of its block
//     ser_busy           at least one block is buffered
//     ser_overflow       sticky flag, set when a block was dropped
module aes_out_serializer #(
  parameter int MSW_FIRST = 1
) (
  input  logic         AES_clk,
  input  logic         AES_rst_n,
  input  logic [127:0] AES_data_out,
  input  logic         AES_data_out_valid,
  input  logic         ser_ready,
  input  logic         ser_ovf_clr,
  output logic [31:0]  ser_data,
  output logic         ser_valid,
  output logic         ser_last,
  output logic         ser_busy,
  output logic         ser_overflow
);

  logic         valid_d;
  logic [127:0] mem [0:1];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic [1:0]   idx;

  logic capture;
  logic xfer;
  logic pop;
  logic push;
  logic drop;

  // Word k of a block, honouring the configured word order.
  function automatic logic [31:0] sel_word(input logic [127:0] blk,
                                           input logic [1:0]   i);
    logic [1:0] k;
    k = (MSW_FIRST != 0) ? ~i : i;
    return blk[{k, 5'b00000} +: 32];
  endfunction

  always_comb begin
    // A level-held valid gives a single capture on its rising edge.
    capture = AES_data_out_valid & ~valid_d;
    xfer    = ser_valid & ser_ready;
    pop     = xfer & (idx == 2'd3);
    // A full FIFO still accepts a block if the head leaves on this same edge.
    push    = capture & ((count != 2'd2) | pop);
    drop    = capture & (count == 2'd2) & ~pop;
  end

  assign ser_valid = (count != 2'd0);
  assign ser_busy  = ser_valid;
  assign ser_last  = ser_valid & (idx == 2'd3);
  // Gated by valid so the output reads 0 while reset holds count at 0,
  // even though the block storage itself is not reset.
  assign ser_data  = ser_valid ? sel_word(mem[rd_ptr], idx) : 32'd0;

  // Control state
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      valid_d      <= 1'b0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= 2'd0;
      idx          <= 2'd0;
      ser_overflow <= 1'b0;
    end else begin
      valid_d <= AES_data_out_valid;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      if (xfer) idx    <= idx + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (drop)             ser_overflow <= 1'b1;
      else if (ser_ovf_clr) ser_overflow <= 1'b0;
    end
  end

  // Block storage
  always_ff @(posedge AES_clk) begin
    if (push) mem[wr_ptr] <= AES_data_out;
  end

endmodule

// File: tb/tb_aes_out_serializer.sv
module tb_aes_out_serializer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] din;
  logic         din_v;
  logic         rdy;
  logic         clr;
  logic [31:0]  m_data, l_data;
  logic         m_valid, m_last, m_busy, m_ovf;
  logic         l_valid, l_last, l_busy, l_ovf;

  always #5 clk = ~clk;

  aes_out_serializer #(.MSW_FIRST(1)) dut (
    .AES_clk(clk), .AES_rst_n(rst_n), .AES_data_out(din),
    .AES_data_out_valid(din_v), .ser_ready(rdy), .ser_ovf_clr(clr),
    .ser_data(m_data), .ser_valid(m_valid), .ser_last(m_last),
    .ser_busy(m_busy), .ser_overflow(m_ovf));

  aes_out_serializer #(.MSW_FIRST(0)) dut_lsw (
    .AES_clk(clk), .AES_rst_n(rst_n), .AES_data_out(din),
    .AES_data_out_valid(din_v), .ser_ready(rdy), .ser_ovf_clr(clr),
    .ser_data(l_data), .ser_valid(l_valid), .ser_last(l_last),
    .ser_busy(l_busy), .ser_overflow(l_ovf));

  // Reference: the outstanding words in send order, one queue per word order.
  logic [31:0] qm[$];
  logic [31:0] ql[$];
  bit          ovf_m;
  bit          vd_m;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int sz;
    logic [31:0] em, el;
    sz = qm.size();
    em = 32'd0;
    el = 32'd0;
    if (sz != 0) begin
      em = qm[0];
      el = ql[0];
    end
    chk({tag, ".valid"},    m_valid, sz != 0);
    chk({tag, ".busy"},     m_busy,  sz != 0);
    chk({tag, ".last"},     m_last,  (sz != 0) && (sz % 4 == 1));
    chk({tag, ".data"},     m_data,  em);
    chk({tag, ".ovf"},      m_ovf,   ovf_m);
    chk({tag, ".lsw_valid"}, l_valid, sz != 0);
    chk({tag, ".lsw_last"},  l_last,  (sz != 0) && (sz % 4 == 1));
    chk({tag, ".lsw_data"},  l_data,  el);
  endtask

  // One clock cycle: drive inputs, advance the model over the edge, check.
  task automatic cyc(input logic v, input logic [127:0] d, input logic r,
                     input logic c, input string tag);
    int  sz, blocks;
    bit  cap, xf, pp;
    din_v = v; din = d; rdy = r; clr = c;
    @(posedge clk);
    sz     = qm.size();
    blocks = (sz + 3) / 4;
    cap    = v && !vd_m;
    xf     = (sz != 0) && r;
    pp     = xf && (sz % 4 == 1);
    if (xf) begin
      void'(qm.pop_front());
      void'(ql.pop_front());
    end
    if (cap) begin
      if (blocks < 2 || pp) begin
        for (int k = 0; k < 4; k++) begin
          qm.push_back(d[127 - 32*k -: 32]);
          ql.push_back(d[32*k +: 32]);
        end
      end else begin
        ovf_m = 1'b1;
      end
    end
    if (!(cap && !(blocks < 2 || pp)) && c) ovf_m = 1'b0;
    vd_m = v;
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    qm.delete();
    ql.delete();
    ovf_m = 1'b0;
    vd_m  = 1'b0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  localparam logic [127:0] BLK = 128'h3925841d_02dc09fb_dc118597_196a0b32;

  initial begin
    logic [127:0] a, b, c2, e;
    int cnt;

    rst_n = 1'b0; din_v = 1'b0; din = '0; rdy = 1'b0; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
    cyc(0, '0, 0, 0, "idle");

    // Single block with the reference vector
    cyc(1, BLK, 1, 0, "blk_w0");
    chk("blk_word0", m_data, 32'h3925841d);
    cyc(0, '0, 1, 0, "blk_w1");
    chk("blk_word1", m_data, 32'h02dc09fb);
    cyc(0, '0, 1, 0, "blk_w2");
    chk("blk_word2", m_data, 32'hdc118597);
    chk("blk_nolast", m_last, 1'b0);
    cyc(0, '0, 1, 0, "blk_w3");
    chk("blk_word3", m_data, 32'h196a0b32);
    chk("blk_last", m_last, 1'b1);
    cyc(0, '0, 1, 0, "blk_done");
    chk("blk_busy0", m_busy, 1'b0);

    // Valid held high: one block only
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      cyc(1, BLK, 1, 0, "held");
      if (m_valid) cnt++;
    end
    cyc(0, '0, 1, 0, "held_end");
    chk("held_words", cnt, 4);
    chk("held_ovf", m_ovf, 1'b0);

    // Backpressure after word 1
    cyc(1, BLK, 1, 0, "bp_w0");
    cyc(0, '0, 1, 0, "bp_w1");
    for (int i = 0; i < 5; i++) begin
      cyc(0, '0, 0, 0, "bp_hold");
      chk("bp_hold_data", m_data, 32'h02dc09fb);
    end
    repeat (4) cyc(0, '0, 1, 0, "bp_resume");

    // Overflow: three captures with ready low, set wins over clear
    a = rnd128(); b = rnd128(); c2 = rnd128();
    cyc(1, a, 0, 0, "ovf_a");
    cyc(0, '0, 0, 0, "ovf_gap");
    cyc(1, b, 0, 0, "ovf_b");
    cyc(0, '0, 0, 0, "ovf_gap");
    cyc(1, c2, 0, 0, "ovf_c");
    chk("ovf_set", m_ovf, 1'b1);
    cyc(0, '0, 0, 0, "ovf_gap");
    cyc(1, c2, 0, 1, "ovf_set_vs_clr");
    chk("ovf_priority", m_ovf, 1'b1);
    for (int i = 0; i < 8; i++) cyc(0, '0, 1, 0, "ovf_drain");
    chk("ovf_drained", m_busy, 1'b0);
    cyc(0, '0, 0, 1, "ovf_clr");
    chk("ovf_cleared", m_ovf, 1'b0);

    // Capture coinciding with the pop of word 3 while full
    a = rnd128(); b = rnd128(); c2 = rnd128();
    cyc(1, a, 0, 0, "coin_a");
    cyc(0, '0, 0, 0, "coin_gap");
    cyc(1, b, 0, 0, "coin_b");
    cyc(0, '0, 1, 0, "coin_x0");
    cyc(0, '0, 1, 0, "coin_x1");
    cyc(0, '0, 1, 0, "coin_x2");
    cyc(1, c2, 1, 0, "coin_cap");
    chk("coin_no_ovf", m_ovf, 1'b0);
    chk("coin_b_word0", m_data, b[127:96]);
    for (int i = 0; i < 8; i++) cyc(0, '0, 1, 0, "coin_drain");
    chk("coin_empty", m_valid, 1'b0);

    // Reset during word 2, valid high at release
    cyc(1, BLK, 1, 0, "rst_w0");
    cyc(0, '0, 1, 0, "rst_w1");
    cyc(0, '0, 1, 0, "rst_w2");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("rst_async");
    chk("rst_data0", m_data, 32'd0);
    e = rnd128();
    din_v = 1'b1; din = e;
    repeat (2) @(posedge clk);
    #1;
    check_all("rst_held");
    rst_n = 1'b1;
    cyc(1, e, 1, 0, "rel_cap");
    chk("rel_word0", m_data, e[127:96]);
    for (int i = 0; i < 5; i++) cyc(1, e, 1, 0, "rel_drain");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 3) == 0), rnd128(), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 15) == 0), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
